// File: rtl/axi_sram_pkg.sv
// Shared types and response/burst encodings for the AXI3 SRAM responder.
package axi_sram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_DATA,
        WR_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    // The encodings are ordered by severity, so the worst response is the larger code.
    function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_beat_addr.sv
// Per-beat address step and SRAM range check for the current transfer address.
module axi_beat_addr
    import axi_sram_pkg::*;
#(
    parameter int RAM_AW = 16
) (
    input  logic [31:0] addr,
    input  logic [1:0]  burst,
    output logic [31:0] next,
    output logic        oob
);

    // WRAP and the reserved encoding step like INCR; 32-bit add wraps naturally.
    assign next = (burst == BURST_FIXED) ? addr : addr + 32'd4;
    assign oob  = |addr[31:RAM_AW+2];

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave serving one read or write burst at a time from a synchronous word SRAM.
module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int RAM_AW = 16,
    parameter int ID_W   = 4
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [ID_W-1:0]   arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ID_W-1:0]   awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ID_W-1:0]   wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_t            state;
    logic              live_q;
    logic              prefer_wr;
    logic [ID_W-1:0]   id_q;
    logic [31:0]       addr_q;
    logic [7:0]        len_q;
    logic [7:0]        beat_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [1:0]        rresp_q;
    logic [1:0]        bresp_q;
    logic [31:0]       rdata_q;
    logic              fresh_q;

    logic [31:0]       next_addr;
    logic              oob;
    logic              proto_err;
    logic              ar_hs;
    logic              aw_hs;
    logic [1:0]        rd_resp;
    logic [1:0]        wr_resp;
    logic [31:0]       rdata_live;

    axi_beat_addr #(.RAM_AW(RAM_AW)) u_beat_addr (
        .addr  (addr_q),
        .burst (burst_q),
        .next  (next_addr),
        .oob   (oob)
    );

    assign proto_err = !(burst_q == BURST_FIXED || burst_q == BURST_INCR) ||
                       (size_q != 3'd2 && len_q != 8'd0);

    // live_q keeps both readies low while reset is held and for the cycle after release.
    assign arready = live_q && (state == IDLE) && !(awvalid && prefer_wr);
    assign awready = live_q && (state == IDLE) && !(arvalid && !prefer_wr);
    assign ar_hs   = arvalid && arready;
    assign aw_hs   = awvalid && awready && !ar_hs;

    assign rd_resp = oob ? RESP_DECERR : (proto_err ? RESP_SLVERR : RESP_OKAY);

    always_comb begin
        wr_resp = RESP_OKAY;
        if (oob)
            wr_resp = RESP_DECERR;
        else if (proto_err || (wid != id_q) || (wlast != (beat_q == len_q)))
            wr_resp = RESP_SLVERR;
    end

    // SRAM data is only live in the first RD_DATA cycle; afterwards the held copy is shown.
    assign rdata_live = (rresp_q == RESP_DECERR) ? 32'd0 : ram_rdata;
    assign rdata      = fresh_q ? rdata_live : rdata_q;
    assign rvalid     = (state == RD_DATA);
    assign rlast      = rvalid && (beat_q == len_q);
    assign rid        = id_q;
    assign rresp      = rresp_q;
    assign wready     = (state == WR_DATA);
    assign bvalid     = (state == WR_RESP);
    assign bid        = id_q;
    assign bresp      = bresp_q;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = addr_q[RAM_AW+1:2];
        ram_wdata = 32'd0;
        if (state == RD_REQ) begin
            ram_en = 1'b1;
        end else if (state == WR_DATA) begin
            ram_wdata = wdata;
            if (wvalid) begin
                ram_en = 1'b1;
                ram_we = oob ? 4'b0000 : wstrb;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            live_q    <= 1'b0;
            prefer_wr <= 1'b0;
            id_q      <= '0;
            addr_q    <= 32'd0;
            len_q     <= 8'd0;
            beat_q    <= 8'd0;
            size_q    <= 3'd0;
            burst_q   <= BURST_FIXED;
            rresp_q   <= RESP_OKAY;
            bresp_q   <= RESP_OKAY;
            rdata_q   <= 32'd0;
            fresh_q   <= 1'b0;
        end else begin
            live_q  <= 1'b1;
            fresh_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        id_q      <= arid;
                        addr_q    <= araddr;
                        len_q     <= arlen;
                        size_q    <= arsize;
                        burst_q   <= arburst;
                        beat_q    <= 8'd0;
                        prefer_wr <= 1'b1;
                        state     <= RD_REQ;
                    end else if (aw_hs) begin
                        id_q      <= awid;
                        addr_q    <= awaddr;
                        len_q     <= awlen;
                        size_q    <= awsize;
                        burst_q   <= awburst;
                        beat_q    <= 8'd0;
                        bresp_q   <= RESP_OKAY;
                        prefer_wr <= 1'b0;
                        state     <= WR_DATA;
                    end
                end
                RD_REQ: begin
                    rresp_q <= rd_resp;
                    fresh_q <= 1'b1;
                    state   <= RD_DATA;
                end
                RD_DATA: begin
                    if (fresh_q)
                        rdata_q <= rdata_live;
                    if (rready) begin
                        if (beat_q == len_q) begin
                            state <= IDLE;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                            addr_q <= next_addr;
                            state  <= RD_REQ;
                        end
                    end
                end
                WR_DATA: begin
                    if (wvalid) begin
                        bresp_q <= resp_worst(bresp_q, wr_resp);
                        beat_q  <= beat_q + 8'd1;
                        addr_q  <= next_addr;
                        if (wlast)
                            state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with an SRAM model, R/B scoreboards and random back-pressure.
module tb_axi_sram_slave;

    localparam int RAM_AW = 16;
    localparam int ID_W   = 4;

    logic              aclk    = 1'b0;
    logic              areset  = 1'b1;
    logic [ID_W-1:0]   arid    = '0;
    logic [31:0]       araddr  = '0;
    logic [7:0]        arlen   = '0;
    logic [2:0]        arsize  = '0;
    logic [1:0]        arburst = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic [ID_W-1:0]   awid    = '0;
    logic [31:0]       awaddr  = '0;
    logic [7:0]        awlen   = '0;
    logic [2:0]        awsize  = '0;
    logic [1:0]        awburst = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [ID_W-1:0]   wid     = '0;
    logic [31:0]       wdata   = '0;
    logic [3:0]        wstrb   = '0;
    logic              wlast   = 1'b0;
    logic              wvalid  = 1'b0;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = '0;

    logic bp_en    = 1'b0;
    logic rready_m = 1'b0;
    logic bready_m = 1'b0;
    logic rready_r = 1'b0;
    logic bready_r = 1'b0;
    assign rready = bp_en ? rready_r : rready_m;
    assign bready = bp_en ? bready_r : bready_m;

    axi_sram_slave #(.RAM_AW(RAM_AW), .ID_W(ID_W)) dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    r_exp_t      r_q[$];
    b_exp_t      b_q[$];
    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];
    int          n_vec = 0;
    int          n_bad = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // SRAM model: one-cycle read latency, byte-enabled writes.
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'd0;
        mem[16'h0040] = 32'hDEADBEEF;
        forever begin
            @(posedge aclk);
            if (ram_en) begin
                if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
                else mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_we);
            end
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            rready_r = 1'($urandom_range(0, 1));
            bready_r = 1'($urandom_range(0, 1));
        end
    end

    // R/B monitor: scoreboard pops plus payload stability while valid waits for ready.
    initial begin
        logic        r_hold, b_hold, plast;
        logic [31:0] pdata;
        logic [3:0]  pid, pbid;
        logic [1:0]  presp, pbresp;
        r_exp_t      re;
        b_exp_t      be;
        r_hold = 1'b0;
        b_hold = 1'b0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                r_hold = 1'b0;
                b_hold = 1'b0;
            end else begin
                if (r_hold) begin
                    chk("r_hold_valid", rvalid, 1);
                    chk("r_hold_data", rdata, pdata);
                    chk("r_hold_id", rid, pid);
                    chk("r_hold_resp", rresp, presp);
                    chk("r_hold_last", rlast, plast);
                end
                if (b_hold) begin
                    chk("b_hold_valid", bvalid, 1);
                    chk("b_hold_id", bid, pbid);
                    chk("b_hold_resp", bresp, pbresp);
                end
                if (rvalid && rready) begin
                    chk("r_expected", r_q.size() != 0, 1);
                    if (r_q.size() != 0) begin
                        re = r_q.pop_front();
                        chk("r_data", rdata, re.data);
                        chk("r_id", rid, re.id);
                        chk("r_resp", rresp, re.resp);
                        chk("r_last", rlast, re.last);
                    end
                end
                if (bvalid && bready) begin
                    chk("b_expected", b_q.size() != 0, 1);
                    if (b_q.size() != 0) begin
                        be = b_q.pop_front();
                        chk("b_id", bid, be.id);
                        chk("b_resp", bresp, be.resp);
                    end
                end
                r_hold = rvalid && !rready;
                b_hold = bvalid && !bready;
                pdata = rdata; pid = rid; presp = rresp; plast = rlast;
                pbid = bid; pbresp = bresp;
            end
        end
    end

    task automatic exp_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] a;
        r_exp_t      e;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            e.id   = id;
            e.last = (i == int'(len));
            if (a[31:RAM_AW+2] != '0) begin
                e.data = 32'd0;
                e.resp = 2'b11;
            end else begin
                e.data = ref_mem[a[RAM_AW+1:2]];
                e.resp = (burst > 2'b01 || (size != 3'd2 && len != 8'd0)) ? 2'b10 : 2'b00;
            end
            r_q.push_back(e);
            if (burst != 2'b00) a = a + 32'd4;
        end
    endtask

    task automatic wait_ar_hs();
        int n = 0;
        do begin @(negedge aclk); n++; end while (!arready && n < 300);
        chk("ar_accept", arready, 1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_aw_hs();
        int n = 0;
        do begin @(negedge aclk); n++; end while (!awready && n < 300);
        chk("aw_accept", awready, 1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
    endtask

    task automatic wait_r_done();
        int n = 0;
        do begin @(negedge aclk); n++; end while (r_q.size() != 0 && n < 300);
        chk("r_drained", r_q.size(), 0);
        @(posedge aclk); #1;
    endtask

    task automatic wait_b_done();
        int n = 0;
        do begin @(negedge aclk); n++; end while (b_q.size() != 0 && n < 300);
        chk("b_drained", b_q.size(), 0);
        @(posedge aclk); #1;
    endtask

    task automatic send_w(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                          input logic [31:0] dbase, input logic [3:0] strb, input int bad_wid);
        logic [31:0] a;
        logic [1:0]  worst, br;
        b_exp_t      e;
        int          n;
        a = addr;
        worst = 2'b00;
        for (int i = 0; i < nbeats; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(posedge aclk); #1;
            end
            wvalid = 1'b1;
            wdata  = dbase * 32'(i + 1);
            wstrb  = strb;
            wlast  = (i == nbeats - 1);
            wid    = (i == bad_wid) ? (id ^ 4'h1) : id;
            n = 0;
            do begin @(negedge aclk); n++; end while (!wready && n < 50);
            chk("w_accept", wready, 1);
            if (a[31:RAM_AW+2] != '0) begin
                br = 2'b11;
            end else begin
                ref_mem[a[RAM_AW+1:2]] = merge(ref_mem[a[RAM_AW+1:2]], wdata, strb);
                br = (burst > 2'b01 || (size != 3'd2 && len != 8'd0) || wid != id ||
                      (wlast && i != int'(len)) || (!wlast && i == int'(len))) ? 2'b10 : 2'b00;
            end
            if (br > worst) worst = br;
            if (burst != 2'b00) a = a + 32'd4;
            @(posedge aclk); #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        e.id   = id;
        e.resp = worst;
        b_q.push_back(e);
    endtask

    task automatic set_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    endtask

    task automatic set_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        set_ar(id, addr, len, size, burst);
        exp_read(id, addr, len, size, burst);
        arvalid = 1'b1;
        wait_ar_hs();
        wait_r_done();
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                            input logic [31:0] dbase, input logic [3:0] strb, input int bad_wid);
        set_aw(id, addr, len, size, burst);
        awvalid = 1'b1;
        wait_aw_hs();
        send_w(id, addr, len, size, burst, nbeats, dbase, strb, bad_wid);
        wait_b_done();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 32'd0;
        ref_mem[16'h0040] = 32'hDEADBEEF;

        // Reset state
        repeat (2) @(negedge aclk);
        chk("rst_arready", arready, 0);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rid", rid, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_bid", bid, 0);
        chk("rst_bresp", bresp, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        bready_m = 1'b1;
        repeat (2) @(posedge aclk);
        #1;

        // Single read with latency check
        set_ar(4'd3, 32'h100, 8'd0, 3'd2, 2'b01);
        exp_read(4'd3, 32'h100, 8'd0, 3'd2, 2'b01);
        arvalid = 1'b1;
        wait_ar_hs();
        @(negedge aclk);
        chk("t1_rvalid_t1", rvalid, 0);
        @(negedge aclk);
        chk("t1_rvalid_t2", rvalid, 1);
        @(posedge aclk); #1;
        rready_m = 1'b1;
        wait_r_done();

        bp_en = 1'b1;

        // INCR write then read-back
        do_write(4'd5, 32'h200, 8'd3, 3'd2, 2'b01, 4, 32'h11, 4'hF, -1);
        do_read(4'd5, 32'h200, 8'd3, 3'd2, 2'b01);
        chk("t2_mem_0x83", mem[16'h0083], 32'h44);

        // Out-of-range accesses
        do_read(4'd2, 32'h0010_0000, 8'd0, 3'd2, 2'b01);
        do_write(4'd2, 32'h0010_0000, 8'd0, 3'd2, 2'b01, 1, 32'hCAFE0001, 4'hF, -1);
        chk("t4_ram_unchanged", mem[16'h0000], ref_mem[16'h0000]);
        do_read(4'd2, 32'h0, 8'd0, 3'd2, 2'b01);

        // Protocol errors, FIXED/WRAP bursts, odd sizes, strobes and address wrap
        do_write(4'd6, 32'h300, 8'd1, 3'd2, 2'b01, 1, 32'h0BAD0000, 4'hF, -1);
        do_write(4'd6, 32'h310, 8'd1, 3'd2, 2'b01, 2, 32'h01010101, 4'hF, 1);
        do_read(4'd6, 32'h310, 8'd1, 3'd2, 2'b01);
        do_write(4'd7, 32'h320, 8'd0, 3'd2, 2'b01, 2, 32'h00770000, 4'hF, -1);
        do_write(4'd8, 32'h330, 8'd2, 3'd2, 2'b00, 3, 32'h1, 4'hF, -1);
        do_read(4'd8, 32'h330, 8'd2, 3'd2, 2'b00);
        do_read(4'd9, 32'h200, 8'd1, 3'd2, 2'b10);
        do_read(4'd9, 32'h200, 8'd1, 3'd1, 2'b01);
        do_read(4'd9, 32'h200, 8'd0, 3'd1, 2'b01);
        do_read(4'd1, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01);
        do_write(4'd4, 32'h204, 8'd0, 3'd2, 2'b01, 1, 32'hA1B2C3D4, 4'b0101, -1);
        chk("t5_strobe_mem", mem[16'h0081], 32'h00B200D4);

        // Arbitration: AR first after a write, then AW is not starved by a new AR
        set_ar(4'd1, 32'h200, 8'd0, 3'd2, 2'b01);
        set_aw(4'd2, 32'h340, 8'd0, 3'd2, 2'b01);
        exp_read(4'd1, 32'h200, 8'd0, 3'd2, 2'b01);
        arvalid = 1'b1;
        awvalid = 1'b1;
        @(negedge aclk);
        chk("t3_first_arready", arready, 1);
        chk("t3_first_awready", awready, 0);
        @(posedge aclk); #1;
        exp_read(4'd1, 32'h200, 8'd0, 3'd2, 2'b01);
        n = 0;
        do begin @(negedge aclk); n++; end while (!(arready || awready) && n < 300);
        chk("t3_second_awready", awready, 1);
        chk("t3_second_arready", arready, 0);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        send_w(4'd2, 32'h340, 8'd0, 3'd2, 2'b01, 1, 32'h5A5A0000, 4'hF, -1);
        wait_ar_hs();
        chk("t3_b_before_ar", b_q.size(), 0);
        wait_r_done();
        wait_b_done();

        // Reset while R is stalled
        bp_en = 1'b0;
        rready_m = 1'b0;
        set_ar(4'd9, 32'h100, 8'd0, 3'd2, 2'b01);
        arvalid = 1'b1;
        wait_ar_hs();
        repeat (3) @(negedge aclk);
        chk("t6_rvalid_stalled", rvalid, 1);
        @(posedge aclk); #1;
        areset = 1'b1;
        #1;
        chk("t6_rvalid_async", rvalid, 0);
        chk("t6_rlast_async", rlast, 0);
        chk("t6_arready_async", arready, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        rready_m = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            chk("t6_no_stale_r", rvalid, 0);
        end
        @(posedge aclk); #1;
        bp_en = 1'b1;
        do_read(4'd10, 32'h100, 8'd0, 3'd2, 2'b01);

        chk("end_r_queue", r_q.size(), 0);
        chk("end_b_queue", b_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
